// File: rtl/next_pc_seq_pkg.sv
// Shared definitions for the registered next-PC sequencer.
// Contents: default widths and the target-selection enum (priority order
// from lowest to highest: sequential, branch, jump, register jump, redirect).
package nextpc_pkg;

    localparam int unsigned PC_W_DEF      = 30;
    localparam int unsigned IMM_W_DEF     = 26;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_REDIR
    } npc_sel_t;

endpackage

// File: rtl/next_pc_seq_ras_stack.sv
// Circular return-address stack.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data on top (overwrites the oldest entry when full)
//   pop         : drop the top entry (ignored when empty)
//   push_data   : return address to save
//   top         : most recently pushed entry still on the stack
//   empty       : no entries held
module ras_stack #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned PC_W      = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty
);

    localparam int unsigned AW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [AW-1:0]   ptr_q;   // next free slot; wraps so a full push lands on the oldest entry
    logic [CW-1:0]   cnt_q;   // saturating occupancy

    assign top   = mem_q[ptr_q - AW'(1)];
    assign empty = (cnt_q == CW'(0));

    // Pointer, occupancy and storage update; pop has priority over push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - AW'(1);
            cnt_q <= cnt_q - CW'(1);
        end else if (push) begin
            mem_q[ptr_q] <= push_data;
            ptr_q        <= ptr_q + AW'(1);
            if (cnt_q != CW'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/next_pc_seq.sv
// Registered fetch-PC sequencer: owns the fetch PC and picks the next one
// each cycle (redirect > register jump > jump > branch > sequential).
// Optional return-address stack enabled by defining NEXTPC_RAS_EN.
// Ports:
//   i_Clk, i_Rst_n        : clock, asynchronous active-low reset
//   i_Ready, i_Stall      : fetch handshake / pipeline hold
//   i_Redirect, i_RedirectPC : flush redirect and its target
//   i_immPC, i_Zero       : immediate field, ALU zero flag
//   i_J, i_Jal, i_Jr      : jump, jump-and-link, register-indirect jump
//   i_Beq, i_Bne          : conditional branches
//   i_RegPC               : register operand for i_Jr
//   o_PC, o_Valid         : registered fetch PC and its valid flag
//   o_PCSrc               : non-sequential target selected (combinational)
//   o_Link                : o_PC+1 link value (combinational)
//   o_RasMiss             : one-cycle pulse on a return from an empty stack
module next_pc_seq
    import nextpc_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     IMM_W     = IMM_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Ready,
    input  logic             i_Stall,
    input  logic             i_Redirect,
    input  logic [PC_W-1:0]  i_RedirectPC,
    input  logic [IMM_W-1:0] i_immPC,
    input  logic             i_Zero,
    input  logic             i_J,
    input  logic             i_Jal,
    input  logic             i_Jr,
    input  logic             i_Beq,
    input  logic             i_Bne,
    input  logic [PC_W-1:0]  i_RegPC,
    output logic [PC_W-1:0]  o_PC,
    output logic             o_Valid,
    output logic             o_PCSrc,
    output logic [PC_W-1:0]  o_Link,
    output logic             o_RasMiss
);

    // Reject parameter sets the datapath cannot represent.
    if ((PC_W < IMM_W + 1) || (IMM_W < 16) || (RAS_DEPTH < 2) ||
        ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_param_check
        $error("next_pc_seq: illegal parameter combination");
    end

    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q;
    logic            ras_miss_q, ras_miss_d;

    logic [PC_W-1:0] seq_c, br_tgt_c, j_tgt_c, jr_tgt_c, tgt_c;
    logic            take_br_c, adv_c;
    npc_sel_t        sel_c;

    assign adv_c     = valid_q & i_Ready & ~i_Stall;
    assign seq_c     = pc_q + PC_W'(1);
    assign br_tgt_c  = seq_c + {{(PC_W-16){i_immPC[15]}}, i_immPC[15:0]};
    assign j_tgt_c   = {seq_c[PC_W-1:IMM_W], i_immPC};
    assign take_br_c = (i_Beq & i_Zero) | (i_Bne & ~i_Zero);

`ifdef NEXTPC_RAS_EN
    logic            ras_push, ras_pop, ras_empty;
    logic [PC_W-1:0] ras_top;

    // Redirect squashes the instruction, so it never touches the stack.
    assign ras_push   = adv_c & i_Jal & ~i_Jr & ~i_Redirect;
    assign ras_pop    = adv_c & i_Jr & ~i_Redirect & ~ras_empty;
    assign jr_tgt_c   = ras_empty ? i_RegPC : ras_top;
    assign ras_miss_d = adv_c & i_Jr & ~i_Redirect & ras_empty;

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk       (i_Clk),
        .rst_n     (i_Rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_c),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    assign jr_tgt_c   = i_RegPC;
    assign ras_miss_d = 1'b0;
`endif

    // Priority encode the target source.
    always_comb begin
        sel_c = SEL_SEQ;
        if (i_Redirect) begin
            sel_c = SEL_REDIR;
        end else if (i_Jr) begin
            sel_c = SEL_JR;
        end else if (i_J || i_Jal) begin
            sel_c = SEL_J;
        end else if (take_br_c) begin
            sel_c = SEL_BR;
        end
    end

    // Target mux and PC update gating (redirect bypasses stall/handshake).
    always_comb begin
        tgt_c = seq_c;
        case (sel_c)
            SEL_REDIR: tgt_c = i_RedirectPC;
            SEL_JR:    tgt_c = jr_tgt_c;
            SEL_J:     tgt_c = j_tgt_c;
            SEL_BR:    tgt_c = br_tgt_c;
            default:   tgt_c = seq_c;
        endcase
        pc_d = (adv_c || i_Redirect) ? tgt_c : pc_q;
    end

    // PC, valid and miss-pulse registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            ras_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= 1'b1;
            ras_miss_q <= ras_miss_d;
        end
    end

    assign o_PC      = pc_q;
    assign o_Valid   = valid_q;
    assign o_PCSrc   = (sel_c != SEL_SEQ);
    assign o_Link    = seq_c;
    assign o_RasMiss = ras_miss_q;

endmodule

// File: tb/tb_next_pc_seq.sv
// Self-checking bench for next_pc_seq: directed scenarios followed by
// randomized control traffic, all compared against a queue-based model.
module tb_next_pc_seq;
    import nextpc_pkg::*;

    localparam int unsigned     PC_W      = 30;
    localparam int unsigned     IMM_W     = 26;
    localparam int unsigned     RAS_DEPTH = 4;
    localparam logic [PC_W-1:0] RESET_PC  = '0;
`ifdef NEXTPC_RAS_EN
    localparam bit HAS_RAS = 1'b1;
`else
    localparam bit HAS_RAS = 1'b0;
`endif

    logic             i_Clk, i_Rst_n, i_Ready, i_Stall, i_Redirect;
    logic [PC_W-1:0]  i_RedirectPC, i_RegPC;
    logic [IMM_W-1:0] i_immPC;
    logic             i_Zero, i_J, i_Jal, i_Jr, i_Beq, i_Bne;
    logic [PC_W-1:0]  o_PC, o_Link;
    logic             o_Valid, o_PCSrc, o_RasMiss;

    next_pc_seq #(
        .PC_W(PC_W), .IMM_W(IMM_W), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Ready(i_Ready), .i_Stall(i_Stall),
        .i_Redirect(i_Redirect), .i_RedirectPC(i_RedirectPC), .i_immPC(i_immPC),
        .i_Zero(i_Zero), .i_J(i_J), .i_Jal(i_Jal), .i_Jr(i_Jr), .i_Beq(i_Beq),
        .i_Bne(i_Bne), .i_RegPC(i_RegPC), .o_PC(o_PC), .o_Valid(o_Valid),
        .o_PCSrc(o_PCSrc), .o_Link(o_Link), .o_RasMiss(o_RasMiss)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [PC_W-1:0] m_pc;
    bit              m_valid;
    bit              m_miss;
    logic [PC_W-1:0] m_ras[$];
    int              sel_hits[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        i_Ready = 1'b1; i_Stall = 1'b0; i_Redirect = 1'b0; i_RedirectPC = '0;
        i_immPC = '0; i_Zero = 1'b0; i_J = 1'b0; i_Jal = 1'b0; i_Jr = 1'b0;
        i_Beq = 1'b0; i_Bne = 1'b0; i_RegPC = '0;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_valid = 1'b0; m_miss = 1'b0; m_ras.delete();
    endtask

    // One clock: predict from current inputs, check comb outputs, clock, check regs.
    task automatic step();
        logic [PC_W-1:0] seq, tgt;
        longint          s;
        int              off;
        bit              adv, pop, push, miss;
        npc_sel_t        sel;
        #1;
        adv  = m_valid && i_Ready && !i_Stall;
        seq  = PC_W'((longint'(m_pc) + 1) % (longint'(1) << PC_W));
        pop  = 1'b0; push = 1'b0; miss = 1'b0;
        if (i_Redirect) begin
            sel = SEL_REDIR; tgt = i_RedirectPC;
        end else if (i_Jr) begin
            sel = SEL_JR;
            if (HAS_RAS && m_ras.size() > 0) begin
                tgt = m_ras[$];
                pop = adv;
            end else begin
                tgt  = i_RegPC;
                miss = HAS_RAS && adv;
            end
        end else if (i_J || i_Jal) begin
            sel = SEL_J;
            s   = (longint'(seq) >> IMM_W) << IMM_W;
            tgt = PC_W'(s + longint'(i_immPC));
        end else if ((i_Beq && i_Zero) || (i_Bne && !i_Zero)) begin
            sel = SEL_BR;
            off = int'($signed(i_immPC[15:0]));
            s   = longint'(seq) + longint'(off);
            tgt = s[PC_W-1:0];
        end else begin
            sel = SEL_SEQ; tgt = seq;
        end
        push = HAS_RAS && adv && i_Jal && !i_Jr && !i_Redirect;
        sel_hits[int'(sel)]++;
        chk("pcsrc", 32'(o_PCSrc), 32'(sel != SEL_SEQ));
        chk("link", 32'(o_Link), 32'(seq));
        @(posedge i_Clk);
        if (push) begin
            m_ras.push_back(seq);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        if (pop) void'(m_ras.pop_back());
        if (adv || i_Redirect) m_pc = tgt;
        m_valid = 1'b1;
        m_miss  = miss;
        #1;
        chk("pc", 32'(o_PC), 32'(m_pc));
        chk("valid", 32'(o_Valid), 32'(m_valid));
        chk("rasmiss", 32'(o_RasMiss), 32'(m_miss));
    endtask

    task automatic redirect_to(input logic [PC_W-1:0] pc);
        clr(); i_Redirect = 1'b1; i_RedirectPC = pc;
        step();
        clr();
    endtask

    logic [PC_W-1:0] ret_exp[5];

    initial begin
        clr();
        model_reset();
        i_Rst_n = 1'b0;
        #12;
        chk("rst_pc", 32'(o_PC), 32'(RESET_PC));
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_miss", 32'(o_RasMiss), 32'd0);
        i_Rst_n = 1'b1;

        // Sequential walk after reset release: first edge only raises valid.
        for (int k = 0; k < 4; k++) begin
            step();
            chk("walk", 32'(o_PC), 32'(k));
        end

        // Backward branch taken / not taken.
        redirect_to(30'd10);
        i_Beq = 1'b1; i_Zero = 1'b1; i_immPC = IMM_W'(16'hFFFC);
        step();
        chk("beq_taken", 32'(o_PC), 32'd7);
        redirect_to(30'd10);
        i_Beq = 1'b1; i_Zero = 1'b0; i_immPC = IMM_W'(16'hFFFC);
        step();
        chk("beq_not_taken", 32'(o_PC), 32'd11);

        // Jump keeps the upper bits of seq; stalled jump holds the PC.
        redirect_to(30'h0400_0005);
        i_J = 1'b1; i_immPC = 26'h0000123;
        step();
        chk("jump", 32'(o_PC), 32'h0400_0123);
        redirect_to(30'h0400_0005);
        i_J = 1'b1; i_immPC = 26'h0000123; i_Stall = 1'b1;
        #1;
        chk("stall_pcsrc", 32'(o_PCSrc), 32'd1);
        step();
        chk("stall_hold", 32'(o_PC), 32'h0400_0005);

        // Redirect overrides stall and a simultaneous jump.
        clr();
        i_Stall = 1'b1; i_Redirect = 1'b1; i_RedirectPC = 30'h80; i_J = 1'b1;
        step();
        chk("redir_stall", 32'(o_PC), 32'h80);

        // Wrap-around of the sequential successor.
        redirect_to({PC_W{1'b1}});
        step();
        chk("wrap", 32'(o_PC), 32'd0);

        // Call chain deeper than the stack, then unwind it.
        redirect_to(30'd1);
        for (int k = 1; k <= 5; k++) begin
            clr(); i_Jal = 1'b1; i_immPC = IMM_W'(k + 1);
            step();
            chk("jal", 32'(o_PC), 32'(k + 1));
        end
        if (HAS_RAS) begin
            ret_exp[0] = 30'd6; ret_exp[1] = 30'd5; ret_exp[2] = 30'd4;
            ret_exp[3] = 30'd3; ret_exp[4] = 30'h3FF;
        end else begin
            for (int k = 0; k < 5; k++) ret_exp[k] = 30'h3FF;
        end
        for (int k = 0; k < 5; k++) begin
            clr(); i_Jr = 1'b1; i_RegPC = 30'h3FF;
            step();
            chk("ret", 32'(o_PC), 32'(ret_exp[k]));
            chk("ret_miss", 32'(o_RasMiss), 32'((k == 4) && HAS_RAS));
        end
        clr();
        step();
        chk("miss_pulse_end", 32'(o_RasMiss), 32'd0);

        // Randomized control traffic.
        for (int n = 0; n < 800; n++) begin
            int kind;
            clr();
            i_Ready      = ($urandom_range(0, 3) != 0);
            i_Stall      = ($urandom_range(0, 4) == 0);
            i_Redirect   = ($urandom_range(0, 15) == 0);
            i_RedirectPC = PC_W'($urandom);
            i_immPC      = IMM_W'($urandom);
            i_Zero       = 1'($urandom);
            i_RegPC      = PC_W'($urandom);
            kind         = $urandom_range(0, 9);
            case (kind)
                3: i_J   = 1'b1;
                4: i_Jal = 1'b1;
                5: i_Jr  = 1'b1;
                6: i_Beq = 1'b1;
                7: i_Bne = 1'b1;
                8: begin i_Beq = 1'b1; i_Bne = 1'b1; end
                9: begin
                    i_J = 1'($urandom); i_Jal = 1'($urandom); i_Jr = 1'($urandom);
                    i_Beq = 1'($urandom); i_Bne = 1'($urandom);
                end
                default: ;
            endcase
            step();
        end

        // Asynchronous reset mid-sequence, then return from an empty stack.
        clr(); i_Jal = 1'b1; i_immPC = IMM_W'(9);
        step();
        i_Rst_n = 1'b0;
        #2;
        chk("midrst_pc", 32'(o_PC), 32'(RESET_PC));
        chk("midrst_valid", 32'(o_Valid), 32'd0);
        chk("midrst_miss", 32'(o_RasMiss), 32'd0);
        model_reset();
        i_Rst_n = 1'b1;
        clr();
        step();
        i_Jr = 1'b1; i_RegPC = 30'h40;
        step();
        chk("empty_ret_pc", 32'(o_PC), 32'h40);
        chk("empty_ret_miss", 32'(o_RasMiss), 32'(HAS_RAS));
        clr();
        step();
        chk("empty_ret_miss_end", 32'(o_RasMiss), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_seq.md
Name: next_pc_seq

Overview:
Parametrised, registered successor to the combinational next-PC logic. Owns the fetch PC register and selects the next PC each cycle with a fixed priority: redirect, then return, then jump, then branch, then sequential. Supports stall, fetch handshake, jump-and-link, and register-indirect return, with an optional return-address stack. Sits between decode/control and the instruction-memory address port of the single-issue core.

Parameters:
PC_W, 30, word-address PC width (byte address >> 2); must be >= IMM_W+1
IMM_W, 26, jump immediate width; branch offset is always imm[15:0]
RESET_PC, 0, PC value loaded at reset (PC_W bits)
RAS_DEPTH, 4, return-address-stack entries; power of 2, >= 2; used only with NEXTPC_RAS_EN

Ports:
i_Clk  in  1  clock, rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Ready  in  1  fetch side accepts the current o_PC
i_Stall  in  1  pipeline hold; PC frozen
i_Redirect  in  1  exception/flush redirect, highest priority
i_RedirectPC  in  PC_W  redirect target
i_immPC  in  IMM_W  instruction immediate field
i_Zero  in  1  ALU zero flag
i_J  in  1  unconditional jump
i_Jal  in  1  jump and link (implies jump)
i_Jr  in  1  register-indirect jump/return
i_Beq  in  1  branch if equal
i_Bne  in  1  branch if not equal
i_RegPC  in  PC_W  register operand for i_Jr
o_PC  out  PC_W  current fetch PC (registered)
o_Valid  out  1  o_PC is valid for fetch
o_PCSrc  out  1  non-sequential target selected this cycle (combinational)
o_Link  out  PC_W  o_PC+1, link value for i_Jal writeback
o_RasMiss  out  1  one-cycle pulse: return popped an empty stack (0 without NEXTPC_RAS_EN)

Behaviour:
- Clocking and reset: one clock (i_Clk). Asynchronous active-low reset (i_Rst_n).
- Reset values: o_PC=RESET_PC, o_Valid=0, o_RasMiss=0, RAS count=0, RAS pointer=0.
- o_Valid rises on the first clock edge after reset release and then stays 1.
- Control inputs describe the instruction at o_PC (single-cycle core). seq = o_PC+1, modulo 2^PC_W.
- adv = o_Valid & i_Ready & ~i_Stall. o_PC updates only when adv=1 or i_Redirect=1; otherwise it holds.
- i_Redirect takes effect even while stalled or not ready, and even when o_Valid=0.
- Target priority:
  1. i_Redirect -> i_RedirectPC
  2. i_Jr -> i_RegPC, or the RAS top (see Optional Feature)
  3. i_J | i_Jal -> {seq[PC_W-1:IMM_W], i_immPC}
  4. (i_Beq & i_Zero) | (i_Bne & ~i_Zero) -> seq + sext(i_immPC[15:0]), wrap modulo 2^PC_W
  5. otherwise -> seq
- o_PCSrc = 1 when any of selections 1-4 is taken in the current cycle, regardless of adv.
- i_Beq and i_Bne asserted together: the branch is taken if either condition holds.
- o_Link is purely combinational from o_PC.
- Sign extension: bit 15 of the offset is replicated up to PC_W bits.
- Wrap-around: o_PC = all-ones with a sequential advance gives 0.

Optional Feature:
Macro: NEXTPC_RAS_EN.
- Present: a circular return-address stack of RAS_DEPTH entries.
  - Push: on adv & i_Jal & ~i_Jr & ~i_Redirect, push o_Link.
  - Overflow: when full, the push overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop: on adv & i_Jr & ~i_Redirect with count>0, pop; the target is the popped entry and i_RegPC is ignored.
  - Empty pop: target = i_RegPC and o_RasMiss pulses for 1 cycle (registered on that edge).
  - i_Jal and i_Jr together: pop only, no push.
  - i_Redirect never modifies the RAS.
- Absent: no stack storage. i_Jr always uses i_RegPC; o_RasMiss is tied to 0.

Decomposition:
- Package nextpc_pkg holds:
  - localparam defaults PC_W_DEF=30 and IMM_W_DEF=26;
  - the selection enum npc_sel_t = {SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_REDIR}, used for priority encoding and bench coverage.
- One sub-module, ras_stack (parameters RAS_DEPTH, PC_W), instantiated only under NEXTPC_RAS_EN. Ports: push, pop, push_data, top, empty; pointer and saturating count inside.

Test Plan:
- Reset then release, i_Ready=1, no controls -> o_Valid=0 during reset, 1 one edge later; o_PC walks 0,1,2,3; o_PCSrc=0.
- o_PC=10, i_Beq=1, i_Zero=1, imm[15:0]=16'hFFFC -> next o_PC=7, o_PCSrc=1. Same stimulus with i_Zero=0 -> o_PC=11.
- o_PC=30'h0400_0005, i_J=1, i_immPC=26'h0000123 -> o_PC=30'h0400_0123. Repeat with i_Stall=1 -> o_PC held, o_PCSrc=1.
- i_Stall=1, i_Redirect=1, i_RedirectPC=30'h80, i_J=1 also asserted -> o_PC=30'h80 on the next edge (redirect wins, stall overridden).
- NEXTPC_RAS_EN, RAS_DEPTH=4:
  - Five i_Jal at PCs 1..5 (link values 2..6), then five i_Jr with i_RegPC=30'h3FF.
  - Required: the returns land on 6,5,4,3; the fifth return goes to 30'h3FF and o_RasMiss pulses once.
- NEXTPC_RAS_EN, empty stack, i_Jr=1, i_RegPC=30'h40 -> o_PC=30'h40, o_RasMiss=1 for exactly 1 cycle. Reset asserted mid-sequence -> RAS count 0, o_PC=RESET_PC immediately.
